pipeline_mem: RTL and testbench

//  Memory stage, directly downstream of the execute stage. Accepts the execute result, store data,

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/mem_align.sv | 51 +++++
 rtl/pipeline_mem.sv | 156 +++++++++++++++
 tb/tb_pipeline_mem.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory stage: memory op codes, access size
// encodings, the bus FSM state type and the store byte-strobe helper.
package pipeline_pkg;

    localparam logic [31:0] MEM_NONE  = 32'd0;
    localparam logic [31:0] MEM_LOAD  = 32'd1;
    localparam logic [31:0] MEM_STORE = 32'd2;

    // Low two bits of the access size field: log2 of the access width in bytes.
    // Bit 2 of the size field selects zero-extension for loads.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } mem_state_t;

    // Byte enables for an access of the given size starting at byte lane 0.
    function automatic logic [7:0] size_strobe(input logic [1:0] size);
        logic [7:0] strb;
        case (size)
            SIZE_B:  strb = 8'h01;
            SIZE_H:  strb = 8'h03;
            SIZE_W:  strb = 8'h0F;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for a 64-bit doubleword memory port: store strobe
// and data shifting, load byte-lane extraction with sign/zero extension, and
// the natural-alignment check.
module mem_align #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            byte_off,
    input  logic [2:0]            size,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_raw,
    output logic [7:0]            wstrb,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned
);
    import pipeline_pkg::*;

    logic [5:0]            lane_shift;
    logic [2:0]            align_mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign_en;

    // Store lanes and alignment: the low address bits that must be zero
    // grow with the access size.
    always_comb begin
        lane_shift = {byte_off, 3'b000};
        wstrb      = size_strobe(size[1:0]) << byte_off;
        wdata      = store_data << lane_shift;
        case (size[1:0])
            SIZE_B:  align_mask = 3'b000;
            SIZE_H:  align_mask = 3'b001;
            SIZE_W:  align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = |(byte_off & align_mask);
    end

    // Load path: move the addressed bytes down to lane 0, then extend.
    // Doubleword loads ignore the zero-extend bit.
    always_comb begin
        shifted = load_raw >> lane_shift;
        sign_en = ~size[2];
        case (size[1:0])
            SIZE_B:  load_data = {{(DATA_WIDTH-8){sign_en & shifted[7]}},   shifted[7:0]};
            SIZE_H:  load_data = {{(DATA_WIDTH-16){sign_en & shifted[15]}}, shifted[15:0]};
            SIZE_W:  load_data = {{(DATA_WIDTH-32){sign_en & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/pipeline_mem.sv
// Memory stage. Takes the execute result, runs aligned loads/stores over a
// req/ack doubleword port, and hands a registered writeback record onward.
//
// Handshakes: the upstream transfer happens on a rising edge where
// in_valid && ready; the downstream transfer happens on a rising edge where
// wb_valid && wb_ready. The bus request is raised in BUS and held, with
// address/data/strobes stable, until the cycle dmem_ack is seen high.
module pipeline_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] ex_res,
    input  logic [DATA_WIDTH-1:0] r2_val_mem,
    input  logic [4:0]            mem_dst_reg,
    input  logic [31:0]           mem_opcode,
    input  logic [2:0]            mem_operation_size,
    input  logic                  ecall_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [7:0]            dmem_wstrb,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [4:0]            wb_dst_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ecall,
    output logic                  wb_misaligned,
    output logic                  dbg_state
);
    import pipeline_pkg::*;

    mem_state_t            state_q, state_d;
    logic                  accept, is_load, is_store, is_mem, start_bus;
    logic                  bus_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic [4:0]            dst_q;
    logic                  ecall_q;

    logic [2:0]            align_off, align_size;
    logic [7:0]            align_wstrb;
    logic [DATA_WIDTH-1:0] align_wdata, align_load;
    logic                  align_misal;

    // Decode the incoming op; unknown opcodes behave as plain ALU results.
    always_comb begin
        is_load   = (mem_opcode == MEM_LOAD);
        is_store  = (mem_opcode == MEM_STORE);
        is_mem    = is_load | is_store;
        accept    = in_valid & ready;
        start_bus = accept & is_mem & ~align_misal;
        bus_done  = (state_q == ST_BUS) & dmem_ack;
        // While a bus access is open the lane logic works on the latched
        // address/size, otherwise on the instruction being offered.
        if (state_q == ST_BUS) begin
            align_off  = addr_q[2:0];
            align_size = size_q;
        end else begin
            align_off  = ex_res[2:0];
            align_size = mem_operation_size;
        end
    end

    mem_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .byte_off   (align_off),
        .size       (align_size),
        .store_data (r2_val_mem),
        .load_raw   (dmem_rdata),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misaligned (align_misal)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: open a bus access on an aligned load/store, close it on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_bus) state_d = ST_BUS;
            ST_BUS:  if (dmem_ack)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: upstream ready only when idle and the wb slot is free or draining.
    always_comb begin
        ready     = (state_q == ST_IDLE) & (~wb_valid | wb_ready);
        dmem_req  = (state_q == ST_BUS);
        dbg_state = state_q;
    end

    // Latch the bus access fields when an aligned load/store is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            dst_q      <= '0;
            ecall_q    <= 1'b0;
        end else if (start_bus) begin
            dmem_we    <= is_store;
            dmem_addr  <= {ex_res[ADDR_WIDTH-1:3], 3'b000};
            dmem_wdata <= is_store ? align_wdata : '0;
            dmem_wstrb <= is_store ? align_wstrb : 8'h00;
            addr_q     <= ex_res;
            size_q     <= mem_operation_size;
            dst_q      <= mem_dst_reg;
            ecall_q    <= ecall_mem;
        end
    end

    // Writeback record: loaded directly for ALU ops and misaligned accesses,
    // or on bus completion; otherwise it drains when the next stage takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid      <= 1'b0;
            wb_dst_reg    <= '0;
            wb_data       <= '0;
            wb_ecall      <= 1'b0;
            wb_misaligned <= 1'b0;
        end else if (accept && !start_bus) begin
            wb_valid      <= 1'b1;
            wb_ecall      <= ecall_mem;
            wb_data       <= DATA_WIDTH'(ex_res);
            wb_misaligned <= is_mem;
            wb_dst_reg    <= is_mem ? 5'd0 : mem_dst_reg;
        end else if (bus_done) begin
            wb_valid      <= 1'b1;
            wb_ecall      <= ecall_q;
            wb_misaligned <= 1'b0;
            wb_dst_reg    <= dmem_we ? 5'd0 : dst_q;
            wb_data       <= dmem_we ? DATA_WIDTH'(addr_q) : align_load;
        end else if (wb_ready) begin
            wb_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_mem.sv
// Directed bench for the memory stage: ALU pass-through, loads with
// sign/zero extension, store lane placement, misaligned accesses, bus and
// writeback back-pressure, back-to-back records and reset during a bus access.
module tb_pipeline_mem;

    localparam logic [31:0] OP_NONE  = 32'd0;
    localparam logic [31:0] OP_LOAD  = 32'd1;
    localparam logic [31:0] OP_STORE = 32'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        ready;
    logic [63:0] ex_res;
    logic [63:0] r2_val_mem;
    logic [4:0]  mem_dst_reg;
    logic [31:0] mem_opcode;
    logic [2:0]  mem_operation_size;
    logic        ecall_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dst_reg;
    logic [63:0] wb_data;
    logic        wb_ecall;
    logic        wb_misaligned;
    logic        dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    pipeline_mem dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .ready              (ready),
        .ex_res             (ex_res),
        .r2_val_mem         (r2_val_mem),
        .mem_dst_reg        (mem_dst_reg),
        .mem_opcode         (mem_opcode),
        .mem_operation_size (mem_operation_size),
        .ecall_mem          (ecall_mem),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_wstrb         (dmem_wstrb),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_dst_reg         (wb_dst_reg),
        .wb_data            (wb_data),
        .wb_ecall           (wb_ecall),
        .wb_misaligned      (wb_misaligned),
        .dbg_state          (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one instruction for exactly one cycle; ready must be high.
    task automatic issue(input logic [31:0] op, input logic [63:0] addr, input logic [63:0] data,
                         input logic [4:0] dst, input logic [2:0] size, input logic ecall);
        @(negedge clk);
        check("ready_at_issue", 64'(ready), 64'd1);
        in_valid           = 1'b1;
        mem_opcode         = op;
        ex_res             = addr;
        r2_val_mem         = data;
        mem_dst_reg        = dst;
        mem_operation_size = size;
        ecall_mem          = ecall;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for the bus request.
    task automatic wait_req();
        int n = 0;
        while (!dmem_req && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_seen", 64'(dmem_req), 64'd1);
    endtask

    task automatic ack(input logic [63:0] rdata);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
    endtask

    // Compare the writeback record against the scoreboard head.
    task automatic check_wb(input string tag, input logic [4:0] dst, input logic misal, input logic ecall);
        check({tag, "_valid"}, 64'(wb_valid), 64'd1);
        check({tag, "_dst"}, 64'(wb_dst_reg), 64'(dst));
        check({tag, "_misal"}, 64'(wb_misaligned), 64'(misal));
        check({tag, "_ecall"}, 64'(wb_ecall), 64'(ecall));
        check({tag, "_queue"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check({tag, "_data"}, wb_data, exp_q.pop_front());
    endtask

    task automatic consume();
        @(negedge clk);
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        check("wb_drained", 64'(wb_valid), 64'd0);
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] size,
                           input logic [4:0] dst, input logic [63:0] rdata, input logic [63:0] exp);
        exp_q.push_back(exp);
        issue(OP_LOAD, addr, 64'h0, dst, size, 1'b0);
        wait_req();
        check({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
        check({tag, "_we"}, 64'(dmem_we), 64'd0);
        check({tag, "_ready_bus"}, 64'(ready), 64'd0);
        ack(rdata);
        check({tag, "_req_drop"}, 64'(dmem_req), 64'd0);
        check_wb(tag, dst, 1'b0, 1'b0);
        consume();
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [2:0] size,
                            input logic [63:0] data, input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        exp_q.push_back(addr);
        issue(OP_STORE, addr, data, 5'd9, size, 1'b0);
        wait_req();
        check({tag, "_we"}, 64'(dmem_we), 64'd1);
        check({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
        check({tag, "_strb"}, 64'(dmem_wstrb), 64'(exp_strb));
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        ack(64'hFFFF_FFFF_FFFF_FFFF);
        check_wb(tag, 5'd0, 1'b0, 1'b0);
        consume();
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; ex_res = '0; r2_val_mem = '0; mem_dst_reg = '0;
        mem_opcode = '0; mem_operation_size = '0; ecall_mem = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0; wb_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_addr", dmem_addr, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ALU pass-through.
        exp_q.push_back(64'h1234);
        issue(OP_NONE, 64'h1234, 64'h0, 5'd5, 3'd3, 1'b0);
        check("alu_req", 64'(dmem_req), 64'd0);
        check_wb("alu", 5'd5, 1'b0, 1'b0);
        check("alu_ready_held", 64'(ready), 64'd0);
        consume();

        // Unknown opcode behaves like an ALU op.
        exp_q.push_back(64'h55);
        issue(32'd7, 64'h55, 64'h0, 5'd3, 3'd2, 1'b0);
        check("unk_req", 64'(dmem_req), 64'd0);
        check_wb("unk", 5'd3, 1'b0, 1'b0);
        consume();

        // Loads with sign/zero extension.
        do_load("lb",  64'h1003, 3'b000, 5'd7, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h1003, 3'b100, 5'd7, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        do_load("lh",  64'h4006, 3'b001, 5'd8, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lw",  64'h4004, 3'b010, 5'd8, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        do_load("lwu", 64'h4004, 3'b110, 5'd8, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
        do_load("ldu", 64'h4000, 3'b111, 5'd8, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

        // Stores: strobe and lane placement.
        do_store("sw", 64'h2004, 3'd2, 64'h0000_0000_DEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        do_store("sb", 64'h5005, 3'd0, 64'h0000_0000_0000_00AB, 8'h20, 64'h0000_AB00_0000_0000);
        do_store("sh", 64'h5006, 3'd1, 64'h0000_0000_0000_1234, 8'hC0, 64'h1234_0000_0000_0000);
        do_store("sd", 64'h5000, 3'd3, 64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708);

        // Misaligned word load: no bus request, exception record.
        exp_q.push_back(64'h2002);
        issue(OP_LOAD, 64'h2002, 64'h0, 5'd4, 3'd2, 1'b0);
        check("mis_req", 64'(dmem_req), 64'd0);
        check_wb("mis", 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("mis_req_later", 64'(dmem_req), 64'd0);
        consume();

        // Delayed ack and writeback back-pressure.
        exp_q.push_back(64'h1122_3344_5566_7788);
        issue(OP_LOAD, 64'h3008, 64'h0, 5'd10, 3'd3, 1'b1);
        wait_req();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dly_req", 64'(dmem_req), 64'd1);
            check("dly_addr", dmem_addr, 64'h3008);
            check("dly_ready", 64'(ready), 64'd0);
        end
        ack(64'h1122_3344_5566_7788);
        check_wb("dly", 5'd10, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(wb_valid), 64'd1);
            check("hold_data", wb_data, 64'h1122_3344_5566_7788);
            check("hold_ready", 64'(ready), 64'd0);
        end
        consume();

        // Back-to-back records with the next stage always ready.
        wb_ready = 1'b1;
        exp_q.push_back(64'h11);
        issue(OP_NONE, 64'h11, 64'h0, 5'd1, 3'd3, 1'b0);
        check_wb("b2b_a", 5'd1, 1'b0, 1'b0);
        exp_q.push_back(64'h22);
        issue(OP_NONE, 64'h22, 64'h0, 5'd2, 3'd3, 1'b1);
        check_wb("b2b_b", 5'd2, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_drain", 64'(wb_valid), 64'd0);
        wb_ready = 1'b0;

        // Bubble: in_valid low accepts nothing, ack outside BUS ignored.
        @(negedge clk);
        mem_opcode = OP_NONE;
        dmem_ack   = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check("bubble_valid", 64'(wb_valid), 64'd0);
        check("bubble_req", 64'(dmem_req), 64'd0);
        check("bubble_ready", 64'(ready), 64'd1);

        // Reset in the middle of a bus access.
        issue(OP_LOAD, 64'h6000, 64'h0, 5'd6, 3'd3, 1'b0);
        wait_req();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstbus_req", 64'(dmem_req), 64'd0);
        check("rstbus_valid", 64'(wb_valid), 64'd0);
        check("rstbus_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(ready), 64'd1);
        check("post_rst_req", 64'(dmem_req), 64'd0);
        check("post_rst_valid", 64'(wb_valid), 64'd0);

        // Recovery: a normal op goes through.
        exp_q.push_back(64'h77);
        issue(OP_NONE, 64'h77, 64'h0, 5'd12, 3'd3, 1'b0);
        check_wb("recover", 5'd12, 1'b0, 1'b0);
        consume();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Overall time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
